// File: rtl/mf_disp_fill_engine.sv
// -----------------------------------------------------------------------------
// mf_disp_fill_engine
//
// Rectangle-fill engine and write arbiter in front of the display top's system
// write port. CPU writes pass straight through combinationally and always win.
// In every cycle without a CPU write, a running fill emits one 32-bit word
// write. Together these writes cover a programmed rectangle with a constant
// word, row by row.
//
// Optional feature (compile-time macro): MF_DISP_FILL_PATTERN_EN
//   defined     : register 5 (PATTERN) exists. Odd-indexed rows write
//                 FILL ^ PATTERN and even rows write FILL.
//   not defined : register 5 is ignored and every row writes FILL.
//
// Register map (cfg_wr_addr):
//   0 DST     [FB_ADDR_W-1:0]  start word address
//   1 SIZE    width [DIM_W-1:0], height [16+DIM_W-1:16]
//   2 STRIDE  [FB_ADDR_W-1:0]  row pitch in words
//   3 FILL    [31:0]
//   4 CTRL    bit0 start, bit1 abort (strobes, not stored)
//   5 PATTERN [31:0]           (only with MF_DISP_FILL_PATTERN_EN)
//   Writes to registers 0-3 and 5 are ignored while fill_busy is high.
//
// Ports:
//   sys_clk, resetn                     clock, asynchronous active-low reset
//   cpu_wr_vld/addr/data                CPU write into display space
//   cfg_wr_vld/addr/data                engine register write
//   sys_wr_vld/addr/data                merged write toward the display top
//   fill_busy                           a fill is running
//   fill_done                           one-cycle pulse on completion or abort
// -----------------------------------------------------------------------------
module mf_disp_fill_engine #(
  parameter int FB_ADDR_W = 16,
  parameter int DIM_W     = 8
) (
  input  logic                 sys_clk,
  input  logic                 resetn,
  input  logic                 cpu_wr_vld,
  input  logic [FB_ADDR_W-1:0] cpu_wr_addr,
  input  logic [31:0]          cpu_wr_data,
  input  logic                 cfg_wr_vld,
  input  logic [2:0]           cfg_wr_addr,
  input  logic [31:0]          cfg_wr_data,
  output logic                 sys_wr_vld,
  output logic [FB_ADDR_W-1:0] sys_wr_addr,
  output logic [31:0]          sys_wr_data,
  output logic                 fill_busy,
  output logic                 fill_done
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;
  logic   done_nxt;

  logic [FB_ADDR_W-1:0] dst;
  logic [DIM_W-1:0]     width;
  logic [DIM_W-1:0]     height;
  logic [FB_ADDR_W-1:0] stride;
  logic [31:0]          fill;
`ifdef MF_DISP_FILL_PATTERN_EN
  logic [31:0]          pattern;
`endif

  logic [FB_ADDR_W-1:0] cur_addr;
  logic [FB_ADDR_W-1:0] row_base;
  logic [DIM_W-1:0]     col;
  logic [DIM_W-1:0]     row;

  logic        ctrl_wr, start, abort, size_ok;
  logic        last_col, last_row;
  logic        load, eng_vld;
  logic [31:0] eng_data;

  assign ctrl_wr  = cfg_wr_vld && (cfg_wr_addr == 3'd4);
  assign start    = ctrl_wr && cfg_wr_data[0];
  assign abort    = ctrl_wr && cfg_wr_data[1];
  assign size_ok  = (width != '0) && (height != '0);
  assign last_col = (col == width - DIM_W'(1));
  assign last_row = (row == height - DIM_W'(1));

  // The CPU owns the port whenever it writes; the engine fills idle cycles only.
  assign eng_vld   = (state == ST_RUN) && !cpu_wr_vld;
  // Abort wins over a simultaneous start.
  assign load      = (state == ST_IDLE) && start && !abort && size_ok;
  assign fill_busy = (state == ST_RUN);

`ifdef MF_DISP_FILL_PATTERN_EN
  assign eng_data = row[0] ? (fill ^ pattern) : fill;
`else
  assign eng_data = fill;
`endif

  assign sys_wr_vld  = cpu_wr_vld || eng_vld;
  assign sys_wr_addr = cpu_wr_vld ? cpu_wr_addr : cur_addr;
  assign sys_wr_data = cpu_wr_vld ? cpu_wr_data : eng_data;

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          if (size_ok) state_nxt = ST_RUN;
          else         done_nxt  = 1'b1;   // empty rectangle: finish at once
        end
      end
      ST_RUN: begin
        if (abort) begin
          // The engine write in this cycle (if any) still goes out.
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end else if (eng_vld && last_col && last_row) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      fill_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      fill_done <= done_nxt;
    end
  end

  // Configuration registers are frozen while a fill runs.
  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      dst     <= '0;
      width   <= '0;
      height  <= '0;
      stride  <= '0;
      fill    <= '0;
`ifdef MF_DISP_FILL_PATTERN_EN
      pattern <= '0;
`endif
    end else if (cfg_wr_vld && !fill_busy) begin
      case (cfg_wr_addr)
        3'd0: dst    <= cfg_wr_data[FB_ADDR_W-1:0];
        3'd1: begin
          width  <= cfg_wr_data[DIM_W-1:0];
          height <= cfg_wr_data[16+DIM_W-1:16];
        end
        3'd2: stride <= cfg_wr_data[FB_ADDR_W-1:0];
        3'd3: fill   <= cfg_wr_data;
`ifdef MF_DISP_FILL_PATTERN_EN
        3'd5: pattern <= cfg_wr_data;
`endif
        default: ;
      endcase
    end
  end

  // Walk counters: they advance only when the engine actually gets the port,
  // so a CPU write simply stalls the walk for one cycle.
  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      cur_addr <= '0;
      row_base <= '0;
      col      <= '0;
      row      <= '0;
    end else if (load) begin
      cur_addr <= dst;
      row_base <= dst;
      col      <= '0;
      row      <= '0;
    end else if (eng_vld) begin
      if (last_col) begin
        col      <= '0;
        row      <= row + DIM_W'(1);
        row_base <= row_base + stride;
        cur_addr <= row_base + stride;
      end else begin
        col      <= col + DIM_W'(1);
        cur_addr <= cur_addr + FB_ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mf_disp_fill_engine.sv
// -----------------------------------------------------------------------------
// Testbench for mf_disp_fill_engine. A transaction-level reference model
// expands each started fill into the full list of (address, data) writes and
// consumes that list in every cycle the CPU leaves free. Random fills, CPU
// traffic, frozen-register writes and aborts run alongside the directed cases.
// -----------------------------------------------------------------------------
module tb_mf_disp_fill_engine;

  localparam int AW = 16;
  localparam int DW = 8;

  logic          sys_clk = 1'b0;
  logic          resetn;
  logic          cpu_wr_vld;
  logic [AW-1:0] cpu_wr_addr;
  logic [31:0]   cpu_wr_data;
  logic          cfg_wr_vld;
  logic [2:0]    cfg_wr_addr;
  logic [31:0]   cfg_wr_data;
  logic          sys_wr_vld;
  logic [AW-1:0] sys_wr_addr;
  logic [31:0]   sys_wr_data;
  logic          fill_busy;
  logic          fill_done;

  mf_disp_fill_engine #(.FB_ADDR_W(AW), .DIM_W(DW)) dut (
    .sys_clk     (sys_clk),
    .resetn      (resetn),
    .cpu_wr_vld  (cpu_wr_vld),
    .cpu_wr_addr (cpu_wr_addr),
    .cpu_wr_data (cpu_wr_data),
    .cfg_wr_vld  (cfg_wr_vld),
    .cfg_wr_addr (cfg_wr_addr),
    .cfg_wr_data (cfg_wr_data),
    .sys_wr_vld  (sys_wr_vld),
    .sys_wr_addr (sys_wr_addr),
    .sys_wr_data (sys_wr_data),
    .fill_busy   (fill_busy),
    .fill_done   (fill_done)
  );

  always #5 sys_clk = ~sys_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit            m_busy, m_done;
  logic [AW-1:0] m_dst, m_stride;
  logic [DW-1:0] m_w, m_h;
  logic [31:0]   m_fill, m_pat;
  logic [AW-1:0] q_addr[$];
  logic [31:0]   q_data[$];
  int            eng_writes;

  task automatic model_reset();
    m_busy = 0; m_done = 0;
    m_dst = '0; m_stride = '0; m_w = '0; m_h = '0; m_fill = '0; m_pat = '0;
    q_addr.delete(); q_data.delete();
  endtask

  // Expand the programmed rectangle into its write list.
  task automatic model_expand();
    logic [AW-1:0] a;
    logic [31:0]   d;
    for (int r = 0; r < int'(m_h); r++) begin
      for (int c = 0; c < int'(m_w); c++) begin
        a = m_dst + AW'(r) * m_stride + AW'(c);
        d = m_fill;
`ifdef MF_DISP_FILL_PATTERN_EN
        if (r % 2 == 1) d = m_fill ^ m_pat;
`endif
        q_addr.push_back(a);
        q_data.push_back(d);
      end
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic cycle(input bit cv, input logic [AW-1:0] ca, input logic [31:0] cd,
                       input bit gv, input logic [2:0] ga, input logic [31:0] gd);
    bit st, ab;
    @(posedge sys_clk);
    #1;
    cpu_wr_vld = cv; cpu_wr_addr = ca; cpu_wr_data = cd;
    cfg_wr_vld = gv; cfg_wr_addr = ga; cfg_wr_data = gd;
    @(negedge sys_clk);
    chk("fill_busy", 32'(fill_busy), 32'(m_busy));
    chk("fill_done", 32'(fill_done), 32'(m_done));
    if (cv) begin
      chk("cpu_vld",  32'(sys_wr_vld), 32'd1);
      chk("cpu_addr", 32'(sys_wr_addr), 32'(ca));
      chk("cpu_data", sys_wr_data, cd);
    end else if (m_busy && q_addr.size() > 0) begin
      chk("eng_vld",  32'(sys_wr_vld), 32'd1);
      chk("eng_addr", 32'(sys_wr_addr), 32'(q_addr[0]));
      chk("eng_data", sys_wr_data, q_data[0]);
    end else begin
      chk("idle_vld", 32'(sys_wr_vld), 32'd0);
    end
    // model update for the coming clock edge
    st = gv && ga == 3'd4 && gd[0];
    ab = gv && ga == 3'd4 && gd[1];
    m_done = 0;
    if (m_busy) begin
      if (!cv && q_addr.size() > 0) begin
        void'(q_addr.pop_front()); void'(q_data.pop_front());
        eng_writes++;
      end
      if (ab || q_addr.size() == 0) begin
        m_busy = 0; m_done = 1;
        q_addr.delete(); q_data.delete();
      end
    end else begin
      if (gv) begin
        case (ga)
          3'd0: m_dst = gd[AW-1:0];
          3'd1: begin m_w = gd[DW-1:0]; m_h = gd[16+DW-1:16]; end
          3'd2: m_stride = gd[AW-1:0];
          3'd3: m_fill = gd;
`ifdef MF_DISP_FILL_PATTERN_EN
          3'd5: m_pat = gd;
`endif
          default: ;
        endcase
      end
      if (st && !ab) begin
        if (m_w != 0 && m_h != 0) begin
          model_expand();
          m_busy = 1;
        end else begin
          m_done = 1;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, '0, '0, 0, '0, '0);
  endtask

  task automatic cfg(input logic [2:0] a, input logic [31:0] d);
    cycle(0, '0, '0, 1, a, d);
  endtask

  task automatic setup(input logic [AW-1:0] dst, input int w, input int h,
                       input logic [AW-1:0] stride, input logic [31:0] f);
    cfg(3'd0, 32'(dst));
    cfg(3'd1, (32'(h) << 16) | 32'(w));
    cfg(3'd2, 32'(stride));
    cfg(3'd3, f);
  endtask

  // Run idle cycles until the model says the fill finished (bounded).
  task automatic drain();
    int k = 0;
    while (m_busy && k < 1000) begin idle(1); k++; end
    chk("drain_timeout", 32'(m_busy), 32'd0);
    idle(2);
  endtask

  task automatic async_reset();
    @(posedge sys_clk);
    #2;
    cpu_wr_vld = 0; cfg_wr_vld = 0;
    resetn = 0;
    #1;
    chk("rst_vld",  32'(sys_wr_vld), 32'd0);
    chk("rst_busy", 32'(fill_busy), 32'd0);
    chk("rst_done", 32'(fill_done), 32'd0);
    model_reset();
    @(negedge sys_clk);
    resetn = 1;
  endtask

  int n_cnt, t_start;

  initial begin
    resetn = 0;
    cpu_wr_vld = 0; cpu_wr_addr = '0; cpu_wr_data = '0;
    cfg_wr_vld = 0; cfg_wr_addr = '0; cfg_wr_data = '0;
    model_reset();
    eng_writes = 0;
    #2;
    chk("reset_vld",  32'(sys_wr_vld), 32'd0);
    chk("reset_busy", 32'(fill_busy), 32'd0);
    chk("reset_done", 32'(fill_done), 32'd0);
    #20;
    @(negedge sys_clk);
    resetn = 1;
    idle(2);

    // Basic 4x3 fill: exactly 12 consecutive writes, then done.
    setup(16'h0100, 4, 3, 16'h0010, 32'hA5A5A5A5);
    eng_writes = 0;
    cfg(3'd4, 32'h1);
    n_cnt = 0;
    for (int i = 0; i < 13; i++) begin
      cycle(0, '0, '0, 0, '0, '0);
      if (sys_wr_vld) n_cnt++;
    end
    chk("basic_nwrites", 32'(n_cnt), 32'd12);
    chk("basic_model_writes", 32'(eng_writes), 32'd12);
    idle(2);

    // Same fill with two CPU writes mid-run.
    eng_writes = 0;
    cfg(3'd4, 32'h1);
    idle(4);
    cycle(1, 16'h1234, 32'hDEADBEEF, 0, '0, '0);
    cycle(1, 16'h4321, 32'hCAFEF00D, 0, '0, '0);
    t_start = 0;
    while (m_busy && t_start < 20) begin idle(1); t_start++; end
    chk("cpu_stall_tail", 32'(t_start), 32'd8);
    idle(2);

    // Zero-width start: no writes, done pulse next cycle.
    setup(16'h0200, 0, 5, 16'h0001, 32'h11111111);
    cfg(3'd4, 32'h1);
    idle(3);

    // Address wrap.
    setup(16'hFFFE, 4, 1, 16'h0000, 32'h5A5A0000);
    cfg(3'd4, 32'h1);
    drain();

    // Abort after 5 writes of 16x16, then registers writable again.
    setup(16'h0300, 16, 16, 16'h0020, 32'h0F0F0F0F);
    cfg(3'd4, 32'h1);
    idle(5);
    cfg(3'd4, 32'h2);
    idle(3);
    setup(16'h0040, 2, 2, 16'h0008, 32'h77777777);
    cfg(3'd4, 32'h1);
    drain();

    // Start with abort together: abort wins, nothing happens.
    cfg(3'd4, 32'h3);
    idle(3);

`ifdef MF_DISP_FILL_PATTERN_EN
    setup(16'h0500, 2, 2, 16'h0010, 32'h00000000);
    cfg(3'd5, 32'hFFFFFFFF);
    cfg(3'd4, 32'h1);
    drain();
`endif

    // Reset mid-fill, then a fill from reset-valued registers.
    setup(16'h0600, 16, 16, 16'h0010, 32'h12345678);
    cfg(3'd4, 32'h1);
    idle(5);
    async_reset();
    idle(2);
    cfg(3'd1, 32'h0001_0003);
    cfg(3'd4, 32'h1);
    drain();

    // Randomized fills with CPU traffic, frozen-register writes and aborts.
    for (int it = 0; it < 40; it++) begin
      setup(AW'($urandom), $urandom_range(0, 6), $urandom_range(0, 4),
            AW'($urandom_range(0, 20)), $urandom);
`ifdef MF_DISP_FILL_PATTERN_EN
      cfg(3'd5, $urandom);
`endif
      cfg(3'd4, 32'h1);
      for (int c = 0; c < 200 && m_busy; c++) begin
        int r = $urandom_range(0, 99);
        if (r < 25)
          cycle(1, AW'($urandom), $urandom, 0, '0, '0);
        else if (r < 35)
          cycle(0, '0, '0, 1, 3'($urandom_range(0, 3)), $urandom);
        else if (r < 37)
          cycle($urandom_range(0, 1) == 1, AW'($urandom), $urandom, 1, 3'd4, 32'h2);
        else if (r < 40)
          cycle(0, '0, '0, 1, 3'd4, 32'h1);
        else
          cycle(0, '0, '0, 0, '0, '0);
      end
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
